// File: rtl/harvard_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : harvard_bus_arbiter
//  Description : Shares one single-port memory bus between the instruction
//                fetch and data ports of a Harvard CPU. Each instruction is
//                sequenced as fetch -> decide -> optional data access ->
//                commit. The CPU only advances during the one-cycle commit
//                (cpu_clk_enable high).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES : consecutive waitrequest-high cycles tolerated within a
//                     single transfer before giving up (0 = never time out)
//    CNT_W          : width of the saturating stall_cycles counter
//  Ports
//    clk, reset_n      : clock, asynchronous active-low reset
//    cpu_active        : CPU wants to run instructions
//    cpu_clk_enable    : one-cycle commit strobe to the CPU
//    instr_address     : fetch address from the CPU
//    instr_readdata    : registered instruction word to the CPU
//    data_address/read/write/writedata : CPU data-port request
//    data_readdata     : registered load data to the CPU
//    bus_*             : single-port memory master interface
//    bus_error         : sticky error (timeout or read+write conflict)
//    stall_cycles      : cycles with cpu_active=1 and the CPU frozen
// ============================================================================
module harvard_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_active,
    output logic             cpu_clk_enable,
    input  logic [31:0]      instr_address,
    output logic [31:0]      instr_readdata,
    input  logic [31:0]      data_address,
    input  logic             data_read,
    input  logic             data_write,
    input  logic [31:0]      data_writedata,
    output logic [31:0]      data_readdata,
    output logic [31:0]      bus_address,
    output logic             bus_read,
    output logic             bus_write,
    output logic [31:0]      bus_writedata,
    output logic [3:0]       bus_byteenable,
    input  logic             bus_waitrequest,
    input  logic [31:0]      bus_readdata,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IFETCH = 3'd1,
        S_DECIDE = 3'd2,
        S_DACC   = 3'd3,
        S_COMMIT = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    // The wait counter only needs to reach TIMEOUT_CYCLES-1: the timeout
    // fires on the wait cycle that would make the count equal the limit.
    localparam int                c_WAIT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT =
        c_WAIT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE   = c_WAIT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic                c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [3:0]          c_BE_ALL     = 4'b1111;

    state_t                state_q,          state_d;
    logic                  bus_read_q,       bus_read_d;
    logic                  bus_write_q,      bus_write_d;
    logic [31:0]           bus_address_q,    bus_address_d;
    logic [31:0]           bus_writedata_q,  bus_writedata_d;
    logic [3:0]            bus_byteenable_q, bus_byteenable_d;
    logic [31:0]           instr_readdata_q, instr_readdata_d;
    logic [31:0]           data_readdata_q,  data_readdata_d;
    logic                  bus_error_q,      bus_error_d;
    logic [CNT_W-1:0]      stall_q,          stall_d;
    logic [c_WAIT_W-1:0]   wait_cnt_q,       wait_cnt_d;

    logic w_strobe;
    logic w_done;
    logic w_timeout;
    logic w_commit;

    assign w_strobe  = bus_read_q | bus_write_q;
    assign w_done    = w_strobe & ~bus_waitrequest;
    // A cycle with waitrequest low always completes; the timeout can only
    // trigger on a cycle that is itself a wait cycle.
    assign w_timeout = c_TIMEOUT_EN & w_strobe & bus_waitrequest & (wait_cnt_q == c_WAIT_LIMIT);
    assign w_commit  = (state_q == S_COMMIT);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        bus_read_d       = bus_read_q;
        bus_write_d      = bus_write_q;
        bus_address_d    = bus_address_q;
        bus_writedata_d  = bus_writedata_q;
        bus_byteenable_d = bus_byteenable_q;
        instr_readdata_d = instr_readdata_q;
        data_readdata_d  = data_readdata_q;
        bus_error_d      = bus_error_q;
        wait_cnt_d       = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_active) begin
                    // Launch the fetch so the strobe is already registered
                    // in the first IFETCH cycle.
                    state_d          = S_IFETCH;
                    bus_read_d       = 1'b1;
                    bus_write_d      = 1'b0;
                    bus_address_d    = instr_address;
                    bus_byteenable_d = c_BE_ALL;
                    wait_cnt_d       = '0;
                end
            end

            S_IFETCH: begin
                if (w_done) begin
                    instr_readdata_d = bus_readdata;
                    bus_read_d       = 1'b0;
                    bus_write_d      = 1'b0;
                    bus_byteenable_d = 4'b0000;
                    state_d          = S_DECIDE;
                end else if (w_timeout) begin
                    bus_read_d       = 1'b0;
                    bus_write_d      = 1'b0;
                    bus_byteenable_d = 4'b0000;
                    bus_error_d      = 1'b1;
                    state_d          = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_WAIT_ONE;
                end
            end

            S_DECIDE: begin
                // The CPU decodes instr_readdata combinationally; its data
                // request is only trusted after this settling cycle.
                if (data_read & data_write) begin
                    bus_error_d = 1'b1;
                    state_d     = S_ERROR;
                end else if (data_read | data_write) begin
                    bus_read_d       = data_read;
                    bus_write_d      = data_write;
                    bus_address_d    = data_address;
                    bus_writedata_d  = data_writedata;
                    bus_byteenable_d = c_BE_ALL;
                    wait_cnt_d       = '0;
                    state_d          = S_DACC;
                end else begin
                    state_d = S_COMMIT;
                end
            end

            S_DACC: begin
                if (w_done) begin
                    if (bus_read_q) begin
                        data_readdata_d = bus_readdata;
                    end
                    bus_read_d       = 1'b0;
                    bus_write_d      = 1'b0;
                    bus_byteenable_d = 4'b0000;
                    state_d          = S_COMMIT;
                end else if (w_timeout) begin
                    bus_read_d       = 1'b0;
                    bus_write_d      = 1'b0;
                    bus_byteenable_d = 4'b0000;
                    bus_error_d      = 1'b1;
                    state_d          = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_WAIT_ONE;
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
            end

            S_ERROR: begin
                // Terminal until reset; the bus was already released on entry.
                bus_error_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall counter saturates rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        if (cpu_active && !w_commit && (stall_q != c_CNT_MAX)) begin
            stall_d = stall_q + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            bus_read_q       <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_address_q    <= '0;
            bus_writedata_q  <= '0;
            bus_byteenable_q <= '0;
            instr_readdata_q <= '0;
            data_readdata_q  <= '0;
            bus_error_q      <= 1'b0;
            stall_q          <= '0;
            wait_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            bus_read_q       <= bus_read_d;
            bus_write_q      <= bus_write_d;
            bus_address_q    <= bus_address_d;
            bus_writedata_q  <= bus_writedata_d;
            bus_byteenable_q <= bus_byteenable_d;
            instr_readdata_q <= instr_readdata_d;
            data_readdata_q  <= data_readdata_d;
            bus_error_q      <= bus_error_d;
            stall_q          <= stall_d;
            wait_cnt_q       <= wait_cnt_d;
        end
    end

    assign cpu_clk_enable = w_commit;
    assign instr_readdata = instr_readdata_q;
    assign data_readdata  = data_readdata_q;
    assign bus_address    = bus_address_q;
    assign bus_read       = bus_read_q;
    assign bus_write      = bus_write_q;
    assign bus_writedata  = bus_writedata_q;
    assign bus_byteenable = bus_byteenable_q;
    assign bus_error      = bus_error_q;
    assign stall_cycles   = stall_q;

endmodule
`default_nettype wire
